minhash_round_scheduler: RTL

- Sequences a shared MinHash/Jaccard datapath through NUM_HASH hash rounds per comparison job.
- Each round generates a fresh (randA, randB) hash pair from an internal LFSR, launches the datapath, collects the two sequence minima and counts equal minima.
- Sits between the job issuer (start/done handshake) and the kmer-hash/min datapath. matchCount/NUM_HASH is the Jaccard similarity estimate.

---
 rtl/minhash_round_scheduler_if.sv | 43 ++++
 rtl/minhash_round_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/minhash_round_scheduler_if.sv
// ---------------------------------------------------------------------------
// minhash_round_scheduler_if
//
// Bundles the job-issuer handshake and the MinHash datapath handshake of
// minhash_round_scheduler into one interface.
//
//   Job side : start, seedLoad, seed   (issuer -> scheduler)
//              busy, done, matchCount, error (scheduler -> issuer)
//   Datapath : dpStart, dpRandA, dpRandB (scheduler -> datapath)
//              dpDone, dpMinOne, dpMinTwo (datapath -> scheduler)
//
// Modports:
//   slave  - the scheduler itself
//   master - whatever drives the scheduler (issuer + datapath, or a bench)
// ---------------------------------------------------------------------------
interface minhash_round_scheduler_if #(
    parameter int KMER_W = 6,
    parameter int CNT_W  = 4
);
    logic                  start;
    logic                  seedLoad;
    logic [2*KMER_W-1:0]   seed;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      matchCount;
    logic                  error;
    logic                  dpStart;
    logic [KMER_W-1:0]     dpRandA;
    logic [KMER_W-1:0]     dpRandB;
    logic                  dpDone;
    logic [KMER_W-1:0]     dpMinOne;
    logic [KMER_W-1:0]     dpMinTwo;

    modport slave (
        input  start, seedLoad, seed, dpDone, dpMinOne, dpMinTwo,
        output busy, done, matchCount, error, dpStart, dpRandA, dpRandB
    );

    modport master (
        output start, seedLoad, seed, dpDone, dpMinOne, dpMinTwo,
        input  busy, done, matchCount, error, dpStart, dpRandA, dpRandB
    );
endinterface

// File: rtl/minhash_round_scheduler.sv
// ---------------------------------------------------------------------------
// minhash_round_scheduler
//
// Runs a shared MinHash datapath through NUM_HASH rounds per comparison job.
// Every round takes a fresh (randA, randB) pair from a 12-bit Fibonacci LFSR,
// launches the datapath, waits for its two sequence minima and counts the
// rounds in which they are equal. matchCount / NUM_HASH estimates Jaccard
// similarity.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - minhash_round_scheduler_if.slave:
//            start/seedLoad/seed in, busy/done/matchCount/error out,
//            dpStart/dpRandA/dpRandB out, dpDone/dpMinOne/dpMinTwo in
//
// Optional feature (macro MINHASH_TIMEOUT_EN):
//   A watchdog counts WAIT cycles; after TIMEOUT cycles without dpDone the
//   job ends through DONE with error=1 and the partial matchCount. error
//   stays set until the next accepted start. Without the macro no counter
//   exists, error is constant 0 and WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module minhash_round_scheduler #(
    parameter int                  KMER_W    = 6,
    parameter int                  NUM_HASH  = 8,
    parameter int                  CNT_W     = 4,
    parameter logic [2*KMER_W-1:0] LFSR_SEED = 12'hACE,
    parameter int                  TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    minhash_round_scheduler_if.slave  bus
);
    localparam int LFSR_W = 2 * KMER_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [CNT_W-1:0]    round_q, round_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dp_start_q, dp_start_d;

`ifdef MINHASH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                error_q, error_d;
`endif

    // Shift left, feedback from taps 11,10,9,3 into bit 0.
    assign lfsr_step = {lfsr_q[LFSR_W-2:0],
                        lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2] ^
                        lfsr_q[LFSR_W-3] ^ lfsr_q[3]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        round_d = round_q;
        match_d = match_q;
`ifdef MINHASH_TIMEOUT_EN
        wd_d    = wd_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A seed load wins over a simultaneous start.
                if (bus.seedLoad) begin
                    lfsr_d = (bus.seed == '0) ? LFSR_SEED : bus.seed;
                end else if (bus.start) begin
                    match_d = '0;
                    round_d = '0;
                    state_d = S_ISSUE;
`ifdef MINHASH_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                // Any dpDone seen here belongs to nothing and is dropped.
                state_d = S_WAIT;
`ifdef MINHASH_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (bus.dpDone) begin
                    if (bus.dpMinOne == bus.dpMinTwo) begin
                        match_d = match_q + CNT_W'(1);
                    end
                    lfsr_d  = lfsr_step;
                    round_d = round_q + CNT_W'(1);
                    state_d = (round_q == CNT_W'(NUM_HASH - 1)) ? S_DONE : S_ISSUE;
                end
`ifdef MINHASH_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // TIMEOUT WAIT cycles elapsed with no result: abort job.
                    state_d = S_DONE;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        dp_start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            round_q    <= '0;
            match_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dp_start_q <= 1'b0;
`ifdef MINHASH_TIMEOUT_EN
            wd_q       <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            round_q    <= round_d;
            match_q    <= match_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dp_start_q <= dp_start_d;
`ifdef MINHASH_TIMEOUT_EN
            wd_q       <= wd_d;
            error_q    <= error_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.matchCount = match_q;
    assign bus.dpStart    = dp_start_q;
    // Multiplier forced odd; both values held by the LFSR until dpDone.
    assign bus.dpRandA    = {lfsr_q[LFSR_W-1 -: KMER_W-1], 1'b1};
    assign bus.dpRandB    = lfsr_q[KMER_W-1:0];

`ifdef MINHASH_TIMEOUT_EN
    assign bus.error      = error_q;
`else
    // No watchdog: constant-false for any legal TIMEOUT, keeps it referenced.
    assign bus.error      = (TIMEOUT < 0);
`endif

endmodule
